noc_link_receiver: RTL
======================

Name: noc_link_receiver

Overview:
- Credit-based receiving end of one router-to-router NoC link.
- Accepts flits from an upstream router output port (data/dest/is_tail/send) into a FIFO of FLIT_BUFFER_DEPTH entries.
- Presents buffered flits downstream with valid/ready and returns one credit pulse per freed slot.
- Tracks packet framing, flags protocol violations and counts received packets. Used to terminate mesh-edge ports and as the link endpoint in link-level test benches.

Parameters:
- FLIT_WIDTH, 64, flit payload width.
- DEST_WIDTH, 4, destination field width (TDEST_WIDTH + TID_WIDTH).
- FLIT_BUFFER_DEPTH, 4, FIFO entries; must be >= 1; equals the credits the upstream sender holds after reset.
- PKT_COUNT_WIDTH, 16, packet counter width.

Ports:
- clk_noc  in  1  NoC clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  FLIT_WIDTH  incoming flit payload.
- dest_in  in  DEST_WIDTH  incoming flit destination.
- is_tail_in  in  1  incoming flit is last of packet.
- send_in  in  1  flit valid this cycle.
- credit_out  out  1  one-cycle pulse: one buffer slot freed.
- out_valid  out  1  head flit available.
- out_ready  in  1  downstream accepts head flit.
- out_data  out  FLIT_WIDTH  head flit payload.
- out_dest  out  DEST_WIDTH  head flit destination.
- out_is_tail  out  1  head flit tail marker.
- overflow_err  out  1  sticky: flit arrived with no free slot.
- proto_err  out  1  sticky: dest changed inside a packet.
- pkt_count  out  PKT_COUNT_WIDTH  packets (tails) accepted into FIFO, wraps.

Behaviour:
- Reset (async assert, synchronous release on clk_noc): FIFO empty, pointers and count 0.
  - Outputs: credit_out=0, out_valid=0, out_data/out_dest/out_is_tail=0, overflow_err=0, proto_err=0, pkt_count=0.
  - FSM=IDLE. No credit pulses are issued on reset exit; the sender preloads FLIT_BUFFER_DEPTH credits.
- Storage:
  - Circular FIFO with read/write pointers of max(1,$clog2(DEPTH)) bits and count of $clog2(DEPTH+1) bits.
  - Pointers wrap from DEPTH-1 to 0; non-power-of-2 depths must work.
- Enqueue:
  - send_in=1 with count<DEPTH, or count==DEPTH with a dequeue in the same cycle: flit written, count updated.
  - Flit is visible at out_* the next cycle (1-cycle latency, first-word-fall-through from registered storage).
- Overflow:
  - send_in=1 with count==DEPTH and no same-cycle dequeue: flit dropped, overflow_err set next cycle and held until reset.
  - FIFO contents and FSM are unchanged.
- Dequeue:
  - Occurs when out_valid && out_ready; head advances.
  - out_valid = (count!=0). out_* are driven from the head entry; when empty, out_* hold the last value and are don't-care.
- Credit:
  - Every dequeue produces credit_out=1 exactly on the following cycle, registered.
  - Back-to-back dequeues give back-to-back pulses; total credits returned equals total flits dequeued.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. When empty, only enqueue occurs (no bypass).
- Packet FSM, evaluated on accepted (non-dropped) flits only:
  - IDLE: tail flit → pkt_count+1, stay IDLE. Non-tail flit → latch dest_in, go to IN_PKT.
  - IN_PKT: if dest_in != latched dest → set proto_err (sticky); the flit is still stored. Tail → pkt_count+1, go to IDLE. Non-tail → stay.
  - pkt_count wraps from 2^PKT_COUNT_WIDTH-1 to 0.
- Reset mid-packet or with a non-empty FIFO: all contents discarded; no credits issued for discarded flits.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with send_in=1 → out_valid=0, credit_out=0, errors=0, pkt_count=0 throughout; no pulses after release.
- Single flit: send data=0xA5, dest=3, tail=1, out_ready=1 → out_valid at cycle+1 with 0xA5/3/1; credit_out pulse at cycle+2; pkt_count=1.
- Fill/backpressure: DEPTH=4, out_ready=0, send 4 flits (tail on 4th) → count 4, no credits. Then out_ready=1 → 4 in-order flits on consecutive cycles, 4 consecutive credit pulses, pkt_count=1.
- Overflow: FIFO full, out_ready=0, send 5th flit 0xFF → overflow_err=1, flit 0xFF never appears at output. A separate case sends with the FIFO full and out_ready=1 → accepted, no error.
- Protocol: 3-flit packet dest=2,2,1 (tail on 3rd) → proto_err=1 after 3rd flit, all 3 flits delivered, pkt_count=1.
- Depth 1 and mid-op reset: DEPTH=1 with send every cycle and out_ready=1 → flits accepted only on alternate cycles without overflow when the sender obeys credits. Asserting rst_n=0 mid-packet → FIFO empty, FSM IDLE; the next 1-flit packet counts pkt_count=1.

Source files
------------

// File: rtl/noc_link_receiver.sv
// Credit-based receiving end of a NoC link: buffers incoming flits in a circular
// FIFO, returns one credit per dequeued flit and checks packet framing.
module noc_link_receiver #(
   parameter int FLIT_WIDTH        = 64,
   parameter int DEST_WIDTH        = 4,
   parameter int FLIT_BUFFER_DEPTH = 4,
   parameter int PKT_COUNT_WIDTH   = 16
) (
   input  logic                       clk_noc,
   input  logic                       rst_n,
   input  logic [FLIT_WIDTH-1:0]      data_in,
   input  logic [DEST_WIDTH-1:0]      dest_in,
   input  logic                       is_tail_in,
   input  logic                       send_in,
   output logic                       credit_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [FLIT_WIDTH-1:0]      out_data,
   output logic [DEST_WIDTH-1:0]      out_dest,
   output logic                       out_is_tail,
   output logic                       overflow_err,
   output logic                       proto_err,
   output logic [PKT_COUNT_WIDTH-1:0] pkt_count
);

   localparam int PTR_W = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
   localparam int CNT_W = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FLIT_BUFFER_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FLIT_BUFFER_DEPTH);

   typedef enum logic {
      IDLE,
      IN_PKT
   } pkt_state_t;

   logic [FLIT_WIDTH-1:0] data_mem [FLIT_BUFFER_DEPTH];
   logic [DEST_WIDTH-1:0] dest_mem [FLIT_BUFFER_DEPTH];
   logic                  tail_mem [FLIT_BUFFER_DEPTH];

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  deq;
   logic                  enq;
   logic                  drop;

   pkt_state_t            state;
   pkt_state_t            next_state;
   logic [DEST_WIDTH-1:0] pkt_dest;
   logic [DEST_WIDTH-1:0] next_pkt_dest;
   logic                  count_pkt;
   logic                  dest_mismatch;

   // A full FIFO can still take a flit when the head leaves in the same cycle.
   assign out_valid = (count != '0);
   assign deq       = out_valid && out_ready;
   assign enq       = send_in && ((count != FULL_CNT) || deq);
   assign drop      = send_in && (count == FULL_CNT) && !deq;

   assign out_data    = data_mem[rd_ptr];
   assign out_dest    = dest_mem[rd_ptr];
   assign out_is_tail = tail_mem[rd_ptr];

   // Storage is cleared on reset so the head outputs read zero afterwards.
   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FLIT_BUFFER_DEPTH; i++) begin
            data_mem[i] <= '0;
            dest_mem[i] <= '0;
            tail_mem[i] <= 1'b0;
         end
      end else if (enq) begin
         data_mem[wr_ptr] <= data_in;
         dest_mem[wr_ptr] <= dest_in;
         tail_mem[wr_ptr] <= is_tail_in;
      end
   end

   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (deq) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
         end
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         credit_out   <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         credit_out <= deq;
         if (drop) begin
            overflow_err <= 1'b1;
         end
      end
   end

   // Framing only tracks flits that actually entered the FIFO.
   always_comb begin
      next_state    = state;
      next_pkt_dest = pkt_dest;
      count_pkt     = 1'b0;
      dest_mismatch = 1'b0;
      if (enq) begin
         case (state)
            IDLE: begin
               if (is_tail_in) begin
                  count_pkt = 1'b1;
               end else begin
                  next_pkt_dest = dest_in;
                  next_state    = IN_PKT;
               end
            end
            IN_PKT: begin
               dest_mismatch = (dest_in != pkt_dest);
               if (is_tail_in) begin
                  count_pkt  = 1'b1;
                  next_state = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pkt_dest  <= '0;
         pkt_count <= '0;
         proto_err <= 1'b0;
      end else begin
         state    <= next_state;
         pkt_dest <= next_pkt_dest;
         if (count_pkt) begin
            pkt_count <= pkt_count + PKT_COUNT_WIDTH'(1);
         end
         if (dest_mismatch) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule
